// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: 1 Hz tick prescaler plus run/set mode FSM that edits and loads hh:mm
module clock_set_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int TIMEOUT_SECS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       tick_en,
  output logic       load,
  output logic [4:0] load_hours,
  output logic [5:0] load_minutes,
  output logic [5:0] load_seconds,
  output logic [1:0] mode,
  output logic [4:0] edit_hours,
  output logic [5:0] edit_minutes,
  output logic       blink
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int IW = $clog2(TIMEOUT_SECS + 1);
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0] P_HALF = PW'(TICK_DIV / 2);
  localparam logic [IW-1:0] I_LAST = IW'(TIMEOUT_SECS - 1);
  typedef enum logic [1:0] {RUN = 2'b00, SET_H = 2'b01, SET_M = 2'b10, COMMIT = 2'b11} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [IW-1:0] idle_q, idle_d;
  logic [4:0] edit_hours_q, edit_hours_d;
  logic [5:0] edit_minutes_q, edit_minutes_d;
  logic tick_q;
  logic wrap, editing, any_btn, timeout;
  logic [4:0] h_inc, h_dec;
  logic [5:0] m_inc, m_dec;
  assign wrap    = presc_q == P_LAST;
  assign editing = state_q == SET_H || state_q == SET_M;
  assign any_btn = btn_mode | btn_inc | btn_dec;
  assign timeout = editing && !any_btn && wrap && idle_q == I_LAST;
  // Out-of-range captured values fall to 0 on the first step in either direction.
  assign h_inc = edit_hours_q >= 5'd23 ? 5'd0 : edit_hours_q + 5'd1;
  assign h_dec = edit_hours_q == 5'd0 ? 5'd23 : edit_hours_q > 5'd23 ? 5'd0 : edit_hours_q - 5'd1;
  assign m_inc = edit_minutes_q >= 6'd59 ? 6'd0 : edit_minutes_q + 6'd1;
  assign m_dec = edit_minutes_q == 6'd0 ? 6'd59 : edit_minutes_q > 6'd59 ? 6'd0 : edit_minutes_q - 6'd1;
  // Next-state: mode sequencing, field editing, idle timeout and prescaler restart on commit.
  always_comb begin
    state_d        = state_q;
    presc_d        = wrap ? '0 : presc_q + 1'b1;
    idle_d         = !editing ? '0 : any_btn ? '0 : wrap ? idle_q + 1'b1 : idle_q;
    edit_hours_d   = edit_hours_q;
    edit_minutes_d = edit_minutes_q;
    case (state_q)
      RUN: if (btn_mode) begin
        state_d        = SET_H;
        edit_hours_d   = cur_hours;
        edit_minutes_d = cur_minutes;
      end
      SET_H: if (btn_mode) state_d = SET_M;
        else if (btn_inc ^ btn_dec) edit_hours_d = btn_inc ? h_inc : h_dec;
      SET_M: if (btn_mode) begin
        state_d = COMMIT;
        presc_d = '0;
      end else if (btn_inc ^ btn_dec) edit_minutes_d = btn_inc ? m_inc : m_dec;
      default: state_d = RUN;
    endcase
    if (timeout) state_d = RUN;
  end
  // State registers; tick is registered so it is exactly one cycle wide.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= RUN;
      presc_q        <= '0;
      idle_q         <= '0;
      edit_hours_q   <= '0;
      edit_minutes_q <= '0;
      tick_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      presc_q        <= presc_d;
      idle_q         <= idle_d;
      edit_hours_q   <= edit_hours_d;
      edit_minutes_q <= edit_minutes_d;
      tick_q         <= wrap && state_q == RUN;
    end
  end
  assign tick_en      = tick_q;
  assign load         = state_q == COMMIT;
  assign load_hours   = load ? edit_hours_q : 5'd0;
  assign load_minutes = load ? edit_minutes_q : 6'd0;
  assign load_seconds = 6'd0;
  assign mode         = state_q;
  assign edit_hours   = edit_hours_q;
  assign edit_minutes = edit_minutes_q;
  assign blink        = editing && presc_q < P_HALF;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed checks of tick, edit, commit, timeout and reset behaviour
module tb_clock_set_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic btn_mode = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0;
  logic [4:0] cur_hours = '0;
  logic [5:0] cur_minutes = '0;
  logic tick_en, load, blink;
  logic [4:0] load_hours, edit_hours;
  logic [5:0] load_minutes, load_seconds, edit_minutes;
  logic [1:0] mode;
  int checks = 0, errors = 0;

  clock_set_ctrl #(.TICK_DIV(4), .TIMEOUT_SECS(3)) dut (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_dec(btn_dec),
    .cur_hours(cur_hours), .cur_minutes(cur_minutes), .tick_en(tick_en), .load(load),
    .load_hours(load_hours), .load_minutes(load_minutes), .load_seconds(load_seconds),
    .mode(mode), .edit_hours(edit_hours), .edit_minutes(edit_minutes), .blink(blink)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic pulse(input logic m, input logic i, input logic d);
    btn_mode = m; btn_inc = i; btn_dec = d;
    @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_dec = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({tick_en, load, blink, mode, edit_hours, edit_minutes, load_hours, load_minutes, load_seconds} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: mode=%0d tick=%b load=%b blink=%b edit=%0d:%0d required all zero",
               mode, tick_en, load, blink, edit_hours, edit_minutes);
    end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      checks++;
      if (tick_en !== (k % 4 == 0) || load !== 1'b0 || blink !== 1'b0) begin
        errors++;
        $display("FAIL run_tick cycle %0d: tick=%b load=%b blink=%b required tick=%b load=0 blink=0",
                 k, tick_en, load, blink, k % 4 == 0);
      end
    end
  endtask

  task automatic test_set_hours();
    int blinks = 0;
    cur_hours = 5'd12; cur_minutes = 6'd34;
    pulse(1, 0, 0);
    checks++;
    if (mode !== 2'd1 || edit_hours !== 5'd12 || edit_minutes !== 6'd34 || tick_en !== 1'b0) begin
      errors++;
      $display("FAIL enter_set_h: mode=%0d edit=%0d:%0d tick=%b required 1 12:34 0", mode, edit_hours, edit_minutes, tick_en);
    end
    for (int k = 0; k < 4; k++) begin
      blinks += int'(blink);
      checks++;
      if (tick_en !== 1'b0 || load !== 1'b0) begin
        errors++;
        $display("FAIL set_h_quiet: tick=%b load=%b required 0 0", tick_en, load);
      end
      @(negedge clk);
    end
    checks++;
    if (blinks != 2) begin
      errors++;
      $display("FAIL blink_duty: got %0d of 4 cycles required 2", blinks);
    end
    for (int k = 0; k < 12; k++) pulse(0, 1, 0);
    checks++;
    if (edit_hours !== 5'd0 || mode !== 2'd1) begin
      errors++;
      $display("FAIL hours_wrap_up: hours=%0d mode=%0d required 0 1", edit_hours, mode);
    end
    pulse(0, 0, 1);
    checks++;
    if (edit_hours !== 5'd23) begin
      errors++;
      $display("FAIL hours_wrap_down: got %0d required 23", edit_hours);
    end
  endtask

  task automatic test_commit();
    do_reset();
    cur_hours = 5'd23; cur_minutes = 6'd59;
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    checks++;
    if (mode !== 2'd2 || edit_hours !== 5'd23 || edit_minutes !== 6'd59) begin
      errors++;
      $display("FAIL enter_set_m: mode=%0d edit=%0d:%0d required 2 23:59", mode, edit_hours, edit_minutes);
    end
    pulse(0, 1, 0);
    checks++;
    if (edit_minutes !== 6'd0) begin
      errors++;
      $display("FAIL minutes_wrap_up: got %0d required 0", edit_minutes);
    end
    pulse(1, 0, 0);
    checks++;
    if (mode !== 2'd3 || load !== 1'b1 || load_hours !== 5'd23 || load_minutes !== 6'd0 || load_seconds !== 6'd0) begin
      errors++;
      $display("FAIL commit_load: mode=%0d load=%b value=%0d:%0d:%0d required 3 1 23:0:0",
               mode, load, load_hours, load_minutes, load_seconds);
    end
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      checks++;
      if (mode !== 2'd0 || load !== 1'b0 || load_hours !== 5'd0 || tick_en !== (j == 4)) begin
        errors++;
        $display("FAIL after_commit cycle %0d: mode=%0d load=%b load_h=%0d tick=%b required 0 0 0 %b",
                 j, mode, load, load_hours, tick_en, j == 4);
      end
    end
  endtask

  task automatic test_timeout();
    logic seen_load = 1'b0;
    do_reset();
    cur_hours = 5'd5; cur_minutes = 6'd10;
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    for (int k = 2; k < 11; k++) begin
      @(negedge clk);
      seen_load |= load;
    end
    checks++;
    if (mode !== 2'd2) begin
      errors++;
      $display("FAIL timeout_early: mode=%0d required 2 before third wrap", mode);
    end
    @(negedge clk);
    checks++;
    if (mode !== 2'd0 || seen_load || load !== 1'b0 || edit_hours !== 5'd5 || edit_minutes !== 6'd10) begin
      errors++;
      $display("FAIL timeout_exit: mode=%0d load_seen=%b edit=%0d:%0d required 0 0 5:10", mode, seen_load, edit_hours, edit_minutes);
    end
    do_reset();
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    for (int k = 2; k < 9; k++) @(negedge clk);
    pulse(0, 1, 0);
    for (int k = 10; k < 19; k++) @(negedge clk);
    checks++;
    if (mode !== 2'd2 || edit_minutes !== 6'd11) begin
      errors++;
      $display("FAIL timeout_restart: mode=%0d min=%0d required 2 11", mode, edit_minutes);
    end
    @(negedge clk);
    checks++;
    if (mode !== 2'd0 || load !== 1'b0) begin
      errors++;
      $display("FAIL timeout_restart_exit: mode=%0d load=%b required 0 0", mode, load);
    end
  endtask

  task automatic test_priority();
    do_reset();
    cur_hours = 5'd7; cur_minutes = 6'd20;
    pulse(0, 1, 0);
    checks++;
    if (mode !== 2'd0 || edit_hours !== 5'd0) begin
      errors++;
      $display("FAIL run_ignores_inc: mode=%0d hours=%0d required 0 0", mode, edit_hours);
    end
    pulse(1, 0, 0);
    pulse(1, 1, 0);
    checks++;
    if (mode !== 2'd2 || edit_hours !== 5'd7) begin
      errors++;
      $display("FAIL mode_beats_inc: mode=%0d hours=%0d required 2 7", mode, edit_hours);
    end
    pulse(0, 1, 1);
    checks++;
    if (edit_minutes !== 6'd20 || mode !== 2'd2) begin
      errors++;
      $display("FAIL inc_dec_cancel: min=%0d mode=%0d required 20 2", edit_minutes, mode);
    end
    pulse(0, 0, 1);
    checks++;
    if (edit_minutes !== 6'd19) begin
      errors++;
      $display("FAIL minutes_dec: got %0d required 19", edit_minutes);
    end
  endtask

  task automatic test_out_of_range();
    do_reset();
    cur_hours = 5'd30; cur_minutes = 6'd61;
    pulse(1, 0, 0);
    checks++;
    if (edit_hours !== 5'd30 || edit_minutes !== 6'd61) begin
      errors++;
      $display("FAIL capture_raw: edit=%0d:%0d required 30:61", edit_hours, edit_minutes);
    end
    pulse(0, 1, 0);
    checks++;
    if (edit_hours !== 5'd0) begin
      errors++;
      $display("FAIL hours_oor_inc: got %0d required 0", edit_hours);
    end
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    checks++;
    if (edit_minutes !== 6'd0) begin
      errors++;
      $display("FAIL minutes_oor_dec: got %0d required 0", edit_minutes);
    end
    pulse(0, 0, 1);
    checks++;
    if (edit_minutes !== 6'd59) begin
      errors++;
      $display("FAIL minutes_wrap_down: got %0d required 59", edit_minutes);
    end
  endtask

  task automatic test_reset_mid_edit();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({tick_en, load, blink, mode, edit_hours, edit_minutes, load_hours, load_minutes} !== '0) begin
      errors++;
      $display("FAIL reset_mid_edit: mode=%0d load=%b blink=%b edit=%0d:%0d required all zero",
               mode, load, blink, edit_hours, edit_minutes);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_set_hours();
    test_commit();
    test_timeout();
    test_priority();
    test_out_of_range();
    test_reset_mid_edit();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
